// File: rtl/dmem_bus_if.sv
// dmem_bus_if: bridges one MEM-stage load/store onto the external data bus with an ack watchdog.
// Build option: define DMEM_MISALIGN_TRAP_EN to reject misaligned half/word accesses without a bus cycle.
module dmem_bus_if #(
    parameter int BIT_WIDTH   = 32,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [BIT_WIDTH-1:0] req_addr,
    input  logic [BIT_WIDTH-1:0] req_wdata,
    output logic                 stall,
    output logic                 resp_valid,
    output logic [BIT_WIDTH-1:0] rdata,
    output logic                 bus_err,
    output logic [BIT_WIDTH-1:0] DAD,
    inout  wire  [BIT_WIDTH-1:0] DDT,
    output logic                 MREQ,
    output logic                 WRITE,
    output logic [1:0]           SIZE,
    input  logic                 ACKD_n,
    output logic                 misalign,
    output logic [1:0]           dbg_state
);

    // Handshake: the core raises req_valid with stable fields and holds them while stall=1.
    // Every accepted access ends in exactly one pulse of resp_valid, bus_err or misalign; stall
    // is low in that cycle, and a req_valid present then is accepted as the next access.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1
    } state_t;

    localparam int TIMER_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    state_t               state;
    logic [TIMER_W-1:0]   timer;
    logic                 l_we;
    logic [2:0]           l_funct3;
    logic [BIT_WIDTH-1:0] ddt_out;
    logic                 reject;

    function automatic logic [1:0] size_code(input logic [1:0] w);
        case (w)
            2'b00:   size_code = 2'b10;
            2'b01:   size_code = 2'b01;
            default: size_code = 2'b00;
        endcase
    endfunction

    function automatic logic [BIT_WIDTH-1:0] store_lanes(input logic [1:0] w,
                                                         input logic [BIT_WIDTH-1:0] d);
        case (w)
            2'b00:   store_lanes = BIT_WIDTH'(d[7:0]);
            2'b01:   store_lanes = BIT_WIDTH'(d[15:0]);
            default: store_lanes = d;
        endcase
    endfunction

    // funct3[2] selects zero fill; otherwise the top bit of the loaded lane is replicated.
    function automatic logic [BIT_WIDTH-1:0] load_extend(input logic [2:0] f,
                                                         input logic [BIT_WIDTH-1:0] d);
        logic fill8;
        logic fill16;
        fill8  = d[7] & ~f[2];
        fill16 = d[15] & ~f[2];
        case (f[1:0])
            2'b00:   load_extend = {{(BIT_WIDTH-8){fill8}}, d[7:0]};
            2'b01:   load_extend = {{(BIT_WIDTH-16){fill16}}, d[15:0]};
            default: load_extend = d;
        endcase
    endfunction

`ifdef DMEM_MISALIGN_TRAP_EN
    assign reject = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    (req_funct3[1] && (req_addr[1:0] != 2'b00));
`else
    assign reject = 1'b0;
`endif

    assign stall = ((state == IDLE && req_valid) || state == ACCESS) &&
                   !(resp_valid || bus_err || misalign);

    // The bus is only driven during a write cycle, so reset releases it with MREQ/WRITE.
    assign DDT = (MREQ && WRITE) ? ddt_out : {BIT_WIDTH{1'bz}};

    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            timer      <= '0;
            l_we       <= 1'b0;
            l_funct3   <= 3'b000;
            ddt_out    <= '0;
            MREQ       <= 1'b0;
            WRITE      <= 1'b0;
            SIZE       <= 2'b00;
            DAD        <= '0;
            rdata      <= '0;
            resp_valid <= 1'b0;
            bus_err    <= 1'b0;
            misalign   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            bus_err    <= 1'b0;
            misalign   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        l_we     <= req_we;
                        l_funct3 <= req_funct3;
                        timer    <= '0;
                        if (reject) begin
                            misalign <= 1'b1;
                        end else begin
                            state   <= ACCESS;
                            MREQ    <= 1'b1;
                            WRITE   <= req_we;
                            DAD     <= req_addr;
                            SIZE    <= size_code(req_funct3[1:0]);
                            ddt_out <= store_lanes(req_funct3[1:0], req_wdata);
                        end
                    end
                end
                ACCESS: begin
                    // An ack on the timeout edge still completes the access normally.
                    if (!ACKD_n) begin
                        state      <= IDLE;
                        MREQ       <= 1'b0;
                        WRITE      <= 1'b0;
                        resp_valid <= 1'b1;
                        if (!l_we) begin
                            rdata <= load_extend(l_funct3, DDT);
                        end
                    end else if (ACK_TIMEOUT != 0 && timer == TIMER_LAST) begin
                        state   <= IDLE;
                        MREQ    <= 1'b0;
                        WRITE   <= 1'b0;
                        bus_err <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    MREQ  <= 1'b0;
                    WRITE <= 1'b0;
                end
            endcase
        end
    end

endmodule
